// File: rtl/rr_encoder_n_to_logn_pkg.sv
// Shared memory-path types: encoder FSM states and the index-width helper
// used by both the one-hot decoder and the round-robin encoder.
package memory_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } enc_state_t;

  // Index width for an n-line vector; never narrower than one bit.
  function automatic int unsigned enc_idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_encoder_n_to_logn_if.sv
// Handshake bundle between a request-vector producer, the encoder and the
// index consumer; master drives the vector and out_ready, slave is the encoder.
interface rr_encoder_n_to_logn_if
  import memory_pkg::*;
#(
  parameter int N = 8
);
  localparam int W = enc_idx_w(N);

  logic [N-1:0] in_vec;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_index;
  logic [N-1:0] out_onehot;
  logic         out_last;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output in_vec, in_valid, out_ready,
    input  in_ready, out_index, out_onehot, out_last, out_valid
  );

  modport slave (
    input  in_vec, in_valid, out_ready,
    output in_ready, out_index, out_onehot, out_last, out_valid
  );

endinterface

// File: rtl/rr_encoder_n_to_logn_first_set.sv
// Wrap-around find-first-set: first set bit of vec at or above start,
// wrapping from N-1 to 0; also flags a vector with exactly one bit set.
module rr_first_set
  import memory_pkg::*;
#(
  parameter int N = 8,
  parameter int W = enc_idx_w(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         found,
  output logic         only_one
);

  logic [W-1:0] pos;

  // Explicit wrap at N-1 keeps non-power-of-two N from visiting dead indices.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = start;
    for (int i = 0; i < N; i++) begin
      if (!found && vec[pos]) begin
        idx   = pos;
        found = 1'b1;
      end
      pos = (pos == W'(N - 1)) ? '0 : pos + 1'b1;
    end
  end

  assign only_one = (vec != '0) && ((vec & (vec - 1'b1)) == '0);

endmodule

// File: rtl/rr_encoder_n_to_logn.sv
// Serialises a multi-hot request vector into binary indices, one per handshake.
// ENC_ROUND_ROBIN_EN: scan pointer advances past each emitted index and persists.
//
// state | meaning
// IDLE  | in_ready=1, waiting for a non-zero vector
// EMIT  | presenting the next set bit of the held vector
module rr_encoder_n_to_logn
  import memory_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  rr_encoder_n_to_logn_if.slave  bus
);

  localparam int W = enc_idx_w(N);
  localparam logic [N-1:0] ONE = N'(1);

  enc_state_t   state_q, state_d;
  logic [N-1:0] vec_q, vec_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic         in_ready_q, in_ready_d;

  logic [W-1:0] fs_idx;
  logic         fs_found;
  logic         fs_only_one;
  logic         emit;

  rr_first_set #(.N(N), .W(W)) u_first_set (
    .vec      (vec_q),
    .start    (ptr_q),
    .idx      (fs_idx),
    .found    (fs_found),
    .only_one (fs_only_one)
  );

  assign emit           = (state_q == EMIT) && fs_found;
  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = emit;
  assign bus.out_index  = emit ? fs_idx : '0;
  assign bus.out_onehot = emit ? (ONE << fs_idx) : '0;
  assign bus.out_last   = emit && fs_only_one;

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    ptr_d      = ptr_q;
    in_ready_d = in_ready_q;
    unique case (state_q)
      IDLE: begin
        // An all-zero vector is accepted and dropped without leaving IDLE.
        if (bus.in_valid && in_ready_q && (bus.in_vec != '0)) begin
          vec_d      = bus.in_vec;
          state_d    = EMIT;
          in_ready_d = 1'b0;
        end
      end
      EMIT: begin
        if (emit && bus.out_ready) begin
          vec_d = vec_q & ~(ONE << fs_idx);
`ifdef ENC_ROUND_ROBIN_EN
          ptr_d = (fs_idx == W'(N - 1)) ? '0 : fs_idx + 1'b1;
`else
          ptr_d = '0;
`endif
          if (fs_only_one) begin
            state_d    = IDLE;
            in_ready_d = 1'b1;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      ptr_q      <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      ptr_q      <= ptr_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: doc/rr_encoder_n_to_logn.md
Name: rr_encoder_n_to_logn

Overview:
- Inverse of the memory-path one-hot address decoder: accepts an N-bit request/select vector and serialises it into binary indices, one set bit per handshake.
- Used on the read/arbitration side of the memory to turn a multi-hot request vector into the log2(N)-bit addresses the decoder consumes.
- Valid/ready on both sides; the held vector is buffered internally and drained bit by bit.

Parameters:
- N, 8, vector width / number of decoded lines; legal N >= 2.
- W, $clog2(N), derived index width; not overridden.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  synchronous reset, active-high.
- in_vec  input  N  request vector, any number of bits set.
- in_valid  input  1  in_vec is valid.
- in_ready  output  1  block can accept a vector; registered.
- out_index  output  W  binary index of the currently presented set bit.
- out_onehot  output  N  one-hot decode of out_index; all-zero when out_valid=0.
- out_last  output  1  current index is the final set bit of the held vector.
- out_valid  output  1  out_index, out_onehot and out_last are valid.
- out_ready  input  1  downstream accepts the current index.

Behaviour:
- Reset values (rst high at a clk edge):
  - state=IDLE, in_ready=1, out_valid=0, out_index=0, out_onehot=0, out_last=0.
  - held vector=0, scan pointer=0.
- FSM states: IDLE, EMIT.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready with in_vec!=0: latch in_vec and go to EMIT. in_ready drops to 0 in the next cycle.
  - On in_valid & in_ready with in_vec==0: the vector is consumed and dropped. Stay in IDLE with in_ready=1 and produce no output.
- EMIT:
  - out_valid=1.
  - out_index = first set bit of the held vector at or above the scan pointer, wrapping modulo N.
  - out_onehot = 1<<out_index.
  - out_last=1 iff exactly one bit remains set.
  - Outputs stay stable while out_ready=0.
- On out_valid & out_ready:
  - Clear that bit in the held vector.
  - If out_last=1, go to IDLE; in_ready=1 from the next cycle.
  - Otherwise present the next set bit in the following cycle.
- Latency: first index is valid 1 cycle after input acceptance. A vector with k set bits occupies the block for k cycles of EMIT plus 1 IDLE cycle, with no back-pressure.
- No fall-through: in_vec presented during EMIT is not sampled (in_ready=0).
- Scan order: ascending from the scan pointer, wrapping from N-1 back to 0.
- Index arithmetic is W bits. Wrap from N-1 to 0 is explicit, because N may be a non-power-of-two.
- Reset mid-EMIT discards the held vector. out_valid drops at that edge; no partial output resumes.

Optional Feature:
- Macro: ENC_ROUND_ROBIN_EN.
- Defined: after each emitted index i, the scan pointer becomes (i+1) mod N and persists across vectors, giving round-robin fairness between successive vectors.
- Undefined: the scan pointer is held at 0, so every vector is emitted in strictly ascending order from bit 0.
- Reset always clears the pointer to 0.

Decomposition:
- Shared package memory_pkg holds:
  - enc_state_t enum {IDLE, EMIT}.
  - A width helper function returning max(1,$clog2(N)), also usable by the decoder.
- One combinational sub-module, rr_first_set, implements the wrap-around find-first-set:
  - Inputs: vec[N-1:0], start[W-1:0].
  - Outputs: idx[W-1:0], found, only_one.
  - The top level holds the FSM, vector register, pointer and handshakes.

Test Plan:
1. Reset, then in_vec=8'b1010_0100 with in_valid=1 and out_ready held 1 -> out_index 2, 5, 7 on three consecutive cycles; out_last only on 7; in_ready=1 the cycle after.
2. in_vec=8'b0000_0000 accepted -> no out_valid pulse, in_ready stays 1, next vector 8'b0000_0001 emits index 0 with out_last=1.
3. in_vec=8'b0001_1000 with out_ready toggling 0,0,1,0,1 -> index 3 held stable for 3 cycles, then index 4, out_onehot matches; in_vec changes during EMIT are ignored.
4. ENC_ROUND_ROBIN_EN defined: vector 8'b0000_0100 (emits 2), then 8'b1000_0101 -> order 7, 0, 2. Undefined: order 0, 2, 7.
5. in_vec=8'b1111_1111, assert rst after 3 indices emitted -> out_valid=0 and in_ready=1 the cycle after reset; a new vector 8'b0100_0000 emits only index 6.
6. N=5, in_vec=5'b10011 with rr pointer at 4 -> order 4, 0, 1 (wrap at non-power-of-two N), W=3.
